// File: rtl/md_sequencer.sv
// ---------------------------------------------------------------------------
// md_sequencer
//
// Sequencer for the multi-cycle multiply/divide unit in the execute stage.
// When a mult or div sits in the D/X latch, it captures the operands, pulses
// the unit's start control for one cycle and holds the pipeline stall. The
// stall is released when the unit reports ready, or when a watchdog expires.
// It then presents the write-back result for exactly one cycle.
//
// Parameters
//   MAX_WAIT      maximum WAIT-state cycles before the watchdog aborts
//                 (1..63, so the 6-bit wait counter can never wrap)
//
// Ports
//   clock         rising-edge clock
//   reset         synchronous, active-high; forces every output to 0
//   ir_dx         instruction in the D/X latch
//   flush         kill from a later stage; aborts any operation in flight
//   opA, opB      bypassed operands of the D/X instruction
//   md_ready      unit result valid (honoured only in WAIT)
//   md_result     unit result
//   md_exception  unit overflow (mult) / divide-by-zero (div)
//   ctrl_mult     one-cycle start pulse, multiply
//   ctrl_div      one-cycle start pulse, divide
//   md_a, md_b    latched operands, stable from START through DONE
//   stall         freezes PC, F/D and D/X
//   res_valid     write-back data valid this cycle
//   res_rd        destination register (30 = rstatus on exception)
//   res_data      write-back value
//   timeout       sticky watchdog flag, cleared only by reset
// ---------------------------------------------------------------------------
module md_sequencer #(
   parameter int MAX_WAIT = 40
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] ir_dx,
   input  logic        flush,
   input  logic [31:0] opA,
   input  logic [31:0] opB,
   input  logic        md_ready,
   input  logic [31:0] md_result,
   input  logic        md_exception,
   output logic        ctrl_mult,
   output logic        ctrl_div,
   output logic [31:0] md_a,
   output logic [31:0] md_b,
   output logic        stall,
   output logic        res_valid,
   output logic [4:0]  res_rd,
   output logic [31:0] res_data,
   output logic        timeout
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_WAIT  = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   localparam logic [5:0]  WAIT_LAST    = 6'(MAX_WAIT - 1);
   localparam logic [4:0]  RD_RSTATUS   = 5'd30;
   localparam logic [4:0]  ALU_MULT     = 5'b00110;
   localparam logic [4:0]  ALU_DIV      = 5'b00111;
   localparam logic [31:0] CODE_MULT_OV = 32'd4;
   localparam logic [31:0] CODE_DIV_Z   = 32'd5;
   localparam logic [31:0] CODE_WDOG    = 32'd6;

   // ------------------------------------------------------------------
   // Registered state
   // ------------------------------------------------------------------
   state_t      state_reg;
   logic [5:0]  count_reg;
   logic [31:0] a_reg;
   logic [31:0] b_reg;
   logic [31:0] result_reg;
   logic [4:0]  rd_reg;
   logic        is_div_reg;
   logic        exc_reg;      // any exception for the current operation
   logic        wd_reg;       // exception was caused by the watchdog
   logic        timeout_reg;

   // ------------------------------------------------------------------
   // Decode of the D/X instruction
   // ------------------------------------------------------------------
   logic [4:0] opcode;
   logic [4:0] aluop;
   logic [4:0] rd_dx;
   logic       is_mult_ir;
   logic       is_div_ir;
   logic       md_class;

   assign opcode     = ir_dx[31:27];
   assign rd_dx      = ir_dx[26:22];
   assign aluop      = ir_dx[6:2];
   assign is_mult_ir = (opcode == 5'b00000) && (aluop == ALU_MULT);
   assign is_div_ir  = (opcode == 5'b00000) && (aluop == ALU_DIV);
   assign md_class   = is_mult_ir || is_div_ir;

   // Instruction bits that play no part in md decode.
   logic unused_ir_bits;
   assign unused_ir_bits = &{1'b0, ir_dx[21:7], ir_dx[1:0]};

   // ------------------------------------------------------------------
   // Sequencer FSM and datapath registers
   // ------------------------------------------------------------------
   always_ff @(posedge clock) begin
      if (reset) begin
         state_reg   <= S_IDLE;
         count_reg   <= '0;
         a_reg       <= '0;
         b_reg       <= '0;
         result_reg  <= '0;
         rd_reg      <= '0;
         is_div_reg  <= 1'b0;
         exc_reg     <= 1'b0;
         wd_reg      <= 1'b0;
         timeout_reg <= 1'b0;
      end else if (flush) begin
         // Abort whatever is in flight; nothing is latched this cycle.
         state_reg <= S_IDLE;
      end else begin
         unique case (state_reg)
            S_IDLE: begin
               if (md_class) begin
                  a_reg      <= opA;
                  b_reg      <= opB;
                  is_div_reg <= is_div_ir;
                  rd_reg     <= rd_dx;
                  exc_reg    <= 1'b0;
                  wd_reg     <= 1'b0;
                  state_reg  <= S_START;
               end
            end

            S_START: begin
               count_reg <= '0;
               state_reg <= S_WAIT;
            end

            S_WAIT: begin
               // A ready arriving on the last allowed cycle beats the watchdog.
               if (md_ready) begin
                  result_reg <= md_result;
                  exc_reg    <= md_exception;
                  state_reg  <= S_DONE;
               end else if (count_reg == WAIT_LAST) begin
                  timeout_reg <= 1'b1;
                  exc_reg     <= 1'b1;
                  wd_reg      <= 1'b1;
                  state_reg   <= S_DONE;
               end else begin
                  count_reg <= count_reg + 6'd1;
               end
            end

            S_DONE: begin
               // Always return to IDLE so the next D/X instruction is
               // evaluated afresh, allowing back-to-back operations.
               state_reg <= S_IDLE;
            end

            default: state_reg <= S_IDLE;
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Output decode. Stall and the start pulses must react in the same
   // cycle as the D/X instruction and flush, so they are combinational
   // decodes of the registered state. Everything is forced low in reset.
   // ------------------------------------------------------------------
   always_comb begin
      ctrl_mult = 1'b0;
      ctrl_div  = 1'b0;
      stall     = 1'b0;
      res_valid = 1'b0;
      res_rd    = '0;
      res_data  = '0;
      if (!reset && !flush) begin
         unique case (state_reg)
            S_IDLE: begin
               stall = md_class;
            end

            S_START: begin
               stall     = 1'b1;
               ctrl_mult = !is_div_reg;
               ctrl_div  = is_div_reg;
            end

            S_WAIT: begin
               stall = 1'b1;
            end

            S_DONE: begin
               res_valid = 1'b1;
               if (exc_reg) begin
                  res_rd = RD_RSTATUS;
                  // Watchdog code overrides the op-specific code.
                  if (wd_reg) begin
                     res_data = CODE_WDOG;
                  end else if (is_div_reg) begin
                     res_data = CODE_DIV_Z;
                  end else begin
                     res_data = CODE_MULT_OV;
                  end
               end else begin
                  res_rd   = rd_reg;
                  res_data = result_reg;
               end
            end

            default: begin
               stall = 1'b0;
            end
         endcase
      end
   end

   assign md_a    = reset ? '0   : a_reg;
   assign md_b    = reset ? '0   : b_reg;
   assign timeout = reset ? 1'b0 : timeout_reg;

endmodule

// File: doc/md_sequencer.md
# md_sequencer

Sequencer for the multi-cycle multiply/divide unit in the execute stage of the 5-stage pipeline. When a `mult` or `div` sits in the D/X latch, the block captures the operands and pulses the unit's start control. It holds the pipeline stall until the unit reports ready, or until a watchdog expires. It then presents the result, the destination register and the exception status for exactly one cycle so the D/X instruction advances with its write-back data.

## Interface
- `MAX_WAIT`, default 40: maximum WAIT-state cycles before the watchdog aborts the operation.
- `clock`  in  1: rising-edge clock.
- `reset`  in  1: synchronous, active-high.
- `ir_dx`  in  32: instruction in the D/X latch.
- `flush`  in  1: kill from a later stage; aborts any operation in flight.
- `opA`, `opB`  in  32 each: bypassed operands for the D/X instruction.
- `md_ready`  in  1: unit result valid.
- `md_result`  in  32: unit result.
- `md_exception`  in  1: overflow (mult) or divide-by-zero (div).
- `ctrl_mult`, `ctrl_div`  out  1 each: one-cycle start pulses to the unit.
- `md_a`, `md_b`  out  32 each: latched operands, held stable from START through DONE.
- `stall`  out  1: freezes PC, F/D and D/X.
- `res_valid`  out  1: write-back data valid this cycle.
- `res_rd`  out  5: destination register.
- `res_data`  out  32: write-back value.
- `timeout`  out  1: sticky watchdog flag, cleared only by reset.

## Operation
- **Decode.** The instruction is md-class when opcode `ir_dx[31:27]` = 00000 and ALUop `ir_dx[6:2]` is 00110 (mult) or 00111 (div). rd is `ir_dx[26:22]`.
- **States.** IDLE, START, WAIT, DONE. A 2-bit state register, a 6-bit wait counter, and registered operand/op/rd/result fields.
- **IDLE.**
  - If md-class and `flush`=0: latch opA, opB, op type and rd; go to START.
  - `stall` is combinational: md-class and not `flush`.
  - Otherwise remain in IDLE with `stall`=0.
- **START.**
  - Drive `ctrl_mult` or `ctrl_div` (decoded from the registered state and op) for this one cycle.
  - `stall`=1; counter cleared; `md_ready` ignored.
  - Go to WAIT.
- **WAIT.**
  - `stall`=1.
  - If `md_ready`: latch `md_result` and `md_exception`; go to DONE.
  - Else if counter = MAX_WAIT-1: set `timeout`, force exception; go to DONE.
  - Else increment the counter.
- **DONE.**
  - `stall`=0 and `res_valid`=1.
  - With no exception: `res_rd` = latched rd, `res_data` = latched result.
  - With an exception: `res_rd` = 30 (rstatus) and `res_data` = 4 (mult overflow), 5 (div by zero) or 6 (watchdog; takes precedence).
  - Always go to IDLE, so the next D/X instruction is evaluated the following cycle. Back-to-back md instructions are allowed.
- **flush.** In START, WAIT or DONE it returns the block to IDLE next cycle. Its effect that same cycle:
  - `stall`=0 and `res_valid`=0.
  - No start pulse in START.
  - No latching.
- **Stale ready.** `md_ready` in IDLE, START or DONE is ignored. A `md_ready` arriving after a flush or timeout therefore has no effect.
- **Width.** All data paths are 32-bit. No arithmetic is performed here except the 6-bit counter, which never wraps because it is bounded by MAX_WAIT ≤ 63.

## Timing
- **Reset.** Effective at the next rising edge with `reset`=1:
  - state = IDLE, counter = 0, `timeout` = 0, latched fields = 0.
  - While `reset` is high, all outputs are forced to 0, including combinational `stall`.
- **Latency.** Cycle 0 is the IDLE detection cycle and cycle 1 is START (pulse). If `md_ready` first rises in cycle 1+k (k ≥ 1), DONE occurs in cycle 2+k. `stall` is high for cycles 0 through 1+k, i.e. k+2 cycles.
- **Watchdog.** Worst case, DONE occurs in cycle 2+MAX_WAIT.
- **Pulse width.** `ctrl_mult`/`ctrl_div` are high for exactly one cycle per operation and never simultaneously.
- **Operand hold.** `md_a`/`md_b` change only on the IDLE→START edge.
- **Ready and timeout together.** If `md_ready` arrives in the same cycle the counter reaches MAX_WAIT-1, the ready wins: normal result, no timeout.

## Test plan
- **mult.** 6 × 7; unit raises ready 3 cycles after the pulse.
  - `ctrl_mult` pulses in cycle 1 with `md_a`=6, `md_b`=7; `stall` high for cycles 0–4.
  - DONE in cycle 5: `res_valid`=1, `res_rd`=rd, `res_data`=42.
- **div by zero.** 9 / 0; ready with exception after 2 cycles.
  - DONE: `res_rd`=30, `res_data`=5; `ctrl_div` was the only pulse.
- **Watchdog.** MAX_WAIT=4, unit never ready.
  - DONE in cycle 6 with `res_rd`=30, `res_data`=6; `timeout`=1 afterward.
  - A late `md_ready` in IDLE is ignored.
- **Flush.** `flush` asserted in the 2nd WAIT cycle.
  - `stall`=0 and `res_valid`=0 that cycle; IDLE next cycle.
  - A subsequent `md_ready` causes no `res_valid`.
- **Back-to-back.** Two mults, the second in D/X right after the first's DONE: two separate start pulses and two `res_valid` cycles.
- **Reset mid-WAIT.** Assert `reset` during WAIT: every output is 0 and the state is IDLE after the edge; a non-md `ir_dx` then gives `stall`=0.
